uart_reg_arbiter: RTL and testbench

Shares the single CPU-side port of uart_registers between two bus requesters: requester 0 is the host CPU bus, requester 1 is the debug/loader port. A round-robin arbiter serialises their accesses. A 3-state FSM drives single-cycle read/write strobes into the register file and returns read data with a valid pulse. Each access is atomic, so a read-clear of the status register is seen by exactly one requester.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_arbiter.sv | 63 ++++++
 rtl/uart_reg_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_reg_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and FSM encoding for the UART register arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register map of uart_registers
    localparam int unsigned UART_STAT_ADDR = 0;
    localparam int unsigned UART_CTRL_ADDR = 1;
    localparam int unsigned UART_TX_ADDR   = 2;
    localparam int unsigned UART_RX_ADDR   = 3;

    // Requester 0 = host CPU bus, requester 1 = debug/loader port
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_arbiter
// Brief    : Two-input round-robin select with last-grant pointer. With
//            UART_ARB_FIXED_PRIO_EN defined, requester 0 always wins and the
//            pointer is not built.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
    import uart_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o
);

`ifdef UART_ARB_FIXED_PRIO_EN
    // Clock, reset and advance have no purpose without a pointer
    logic w_unused;
    assign w_unused = ^{clk_i, rst_ni, adv_i};

    // Requester 0 always has priority
    always_comb begin
        gnt_o = '0;
        if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
    end
`else
    logic ptr_q;
    logic ptr_d;

    // On a tie the requester that did not win last time is selected
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
        if (adv_i && (|req_i)) begin
            ptr_d = gnt_o[1];
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/uart_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_arbiter
// Brief    : Serialises host CPU and debug/loader accesses onto the single
//            CPU port of uart_registers. IDLE -> ACCESS -> RESP sequence,
//            one strobe cycle per access, read data captured pre-clear.
//            Build option: UART_ARB_FIXED_PRIO_EN selects fixed priority
//            (requester 0 wins) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module uart_reg_arbiter
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic [ADDR_WIDTH-1:0]           cpu_addr_o,
    output logic [DATA_WIDTH-1:0]           cpu_data_o,
    output logic                            wr_en_cpu_o,
    output logic                            rd_en_cpu_o,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] reg_data_i
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       w_sample;

    logic [NUM_REQ-1:0]    w_win;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_regs [REG_COUNT];

    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] cpu_addr_q;
    logic [DATA_WIDTH-1:0] cpu_data_q;
    logic                  wr_en_q;
    logic                  rd_en_q;

    uart_rr_arbiter u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_i),
        .adv_i  (w_sample),
        .gnt_o  (w_win)
    );

    // Flattened register-file read bus viewed as an array
    for (genvar i = 0; i < REG_COUNT; i++) begin : g_unpack
        assign w_regs[i] = reg_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Winner's request fields
    always_comb begin
        w_we    = w_win[1] ? we_i[1] : we_i[0];
        w_addr  = w_win[1] ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : addr_i[ADDR_WIDTH-1:0];
        w_wdata = w_win[1] ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                           : wdata_i[DATA_WIDTH-1:0];
    end

    // Next state; requests are only looked at in IDLE and RESP
    always_comb begin
        state_d  = state_q;
        w_sample = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    w_sample = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (|req_i) begin
                    w_sample = 1'b1;
                    state_d  = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes/grant launched on entry to ACCESS; completion and read capture
    // at the end of ACCESS, on the same edge the register file clears status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            cpu_addr_q <= '0;
            cpu_data_q <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            gnt_q    <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            rvalid_q <= '0;
            if (w_sample) begin
                gnt_q      <= w_win;
                cpu_addr_q <= w_addr;
                cpu_data_q <= w_we ? w_wdata : '0;
                wr_en_q    <= w_we;
                rd_en_q    <= ~w_we;
            end
            if (state_q == ACCESS) begin
                rvalid_q <= gnt_q;
                if (rd_en_q) begin
                    rdata_q <= w_regs[cpu_addr_q];
                end
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign cpu_addr_o  = cpu_addr_q;
    assign cpu_data_o  = cpu_data_q;
    assign wr_en_cpu_o = wr_en_q;
    assign rd_en_cpu_o = rd_en_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_reg_arbiter
// Brief    : Directed self-checking bench for uart_reg_arbiter with a small
//            register-file model and a completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [3:0]  addr;
    logic [63:0] wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, cpu_data;
    logic [1:0]  cpu_addr;
    logic        wr_en, rd_en;
    logic [127:0] reg_data;

    always #5 clk = ~clk;

    uart_reg_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .REG_COUNT(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .cpu_addr_o  (cpu_addr),
        .cpu_data_o  (cpu_data),
        .wr_en_cpu_o (wr_en),
        .rd_en_cpu_o (rd_en),
        .reg_data_i  (reg_data)
    );

    // Register-file model: writes, status read-clear, peripheral status set
    logic [31:0] regs [4];
    logic        model_clr, periph_set;
    logic [31:0] periph_val;
    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (wr_en) regs[cpu_addr] <= cpu_data;
            if (rd_en && cpu_addr == 2'd0) regs[0] <= '0;
            if (periph_set) regs[0] <= periph_val;
        end
    end
    assign reg_data = {regs[3], regs[2], regs[1], regs[0]};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  who;
        logic        is_rd;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input logic [1:0] who, input logic is_rd, input logic [31:0] d);
        exp_t e;
        e.who = who; e.is_rd = is_rd; e.data = d;
        sbq.push_back(e);
    endtask

    // Completion monitor: pops the scoreboard on every rvalid pulse
    always @(negedge clk) begin
        if (rvalid !== 2'b00) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rvalid", {94'd0, rvalid}, 96'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rvalid_who", {94'd0, rvalid}, {94'd0, e.who});
                if (e.is_rd) chk("rdata", {64'd0, rdata}, {64'd0, e.data});
            end
        end
    end

    // One access from a single requester starting from IDLE
    task automatic single(input int r, input logic w, input logic [1:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        int n;
        logic [1:0] oh;
        oh = 2'(1 << r);
        req = '0;
        req[r] = 1'b1;
        we[r] = w;
        addr[r*2 +: 2] = a;
        wdata[r*32 +: 32] = d;
        push(oh, !w, exp_rd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt[r] !== 1'b1 && n < 10);
        chk("gnt_latency", 96'(n), 96'd1);
        chk("gnt", {94'd0, gnt}, {94'd0, oh});
        chk("wr_en", {95'd0, wr_en}, {95'd0, w});
        chk("rd_en", {95'd0, rd_en}, {95'd0, !w});
        chk("cpu_addr", {94'd0, cpu_addr}, {94'd0, a});
        chk("cpu_data", {64'd0, cpu_data}, {64'd0, (w ? d : 32'd0)});
        req = '0;
        @(negedge clk);
        chk("rvalid_time", {94'd0, rvalid}, {94'd0, oh});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic tb_last;
        logic [1:0] exp_g;

        rst_n = 1'b0; model_clr = 1'b1; periph_set = 1'b0; periph_val = '0;
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; model_clr = 1'b0;

        // Idle after reset: every output zero
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {24'd0, gnt, rvalid, rdata, cpu_addr, cpu_data, wr_en, rd_en}, 96'd0);
        end

        // First tie after reset goes to requester 0; then requester 1 writes 0x33 to addr 3
        req = 2'b11; we = 2'b10; addr = {2'd3, 2'd1}; wdata = {32'h33, 32'h0};
        push(2'b01, 1'b1, 32'h0);
        push(2'b10, 1'b0, 32'h0);
        @(negedge clk);
        chk("tie_gnt", {94'd0, gnt}, 96'h1);
        chk("tie_rd_en", {95'd0, rd_en}, 96'h1);
        chk("tie_addr", {94'd0, cpu_addr}, 96'h1);
        req = 2'b10;
        @(negedge clk);
        chk("resp_no_gnt", {94'd0, gnt}, 96'h0);
        @(negedge clk);
        chk("second_gnt", {94'd0, gnt}, 96'h2);
        chk("second_wr", {95'd0, wr_en}, 96'h1);
        chk("second_data", {64'd0, cpu_data}, 96'h33);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Requester 1 writes 0xA5 to addr 2, requester 0 reads it back
        single(1, 1'b1, 2'd2, 32'hA5, 32'h0);
        single(0, 1'b0, 2'd2, 32'h0, 32'hA5);

        // Status read-clear
        periph_set = 1'b1; periph_val = 32'h0001_0001;
        @(negedge clk);
        periph_set = 1'b0;
        single(0, 1'b0, 2'd0, 32'h0, 32'h0001_0001);
        single(0, 1'b0, 2'd0, 32'h0, 32'h0);

        // Continuous load from both requesters, 8 accesses
        tb_last = 1'b0;
        req = 2'b11; we = 2'b00; addr = {2'd2, 2'd3};
        for (int g = 0; g < 8; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (gnt === 2'b00 && n < 4);
            chk("grant_spacing", 96'(n), (g == 0) ? 96'd1 : 96'd2);
`ifdef UART_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = tb_last ? 2'b01 : 2'b10;
`endif
            chk("rr_gnt", {94'd0, gnt}, {94'd0, exp_g});
            push(exp_g, 1'b1, exp_g[0] ? 32'h33 : 32'hA5);
            tb_last = exp_g[1];
            if (g == 7) req = 2'b00;
        end
        repeat (2) @(negedge clk);

        // Reset during ACCESS drops the access
        req = 2'b01; we = 2'b00; addr = {2'd0, 2'd3};
        @(negedge clk);
        chk("pre_reset_gnt", {94'd0, gnt}, 96'h1);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", {24'd0, gnt, rvalid, rdata, cpu_addr, cpu_data, wr_en, rd_en}, 96'd0);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rvalid_after_reset", {94'd0, rvalid}, 96'h0);
        end
        single(0, 1'b0, 2'd3, 32'h0, 32'h33);

        // Address change during ACCESS is ignored
        req = 2'b10; we = 2'b00; addr = {2'd2, 2'd0};
        push(2'b10, 1'b1, 32'hA5);
        @(negedge clk);
        chk("inflight_gnt", {94'd0, gnt}, 96'h2);
        chk("inflight_addr", {94'd0, cpu_addr}, 96'h2);
        addr = {2'd3, 2'd0};
        req = 2'b00;
        @(negedge clk);
        chk("inflight_rvalid", {94'd0, rvalid}, 96'h2);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 96'(sbq.size()), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
